// File: rtl/corrode_ctrl_if.sv
// Pixel/decision link between camera stream, corrosion block and corrode_ctrl.
// master = controller side; slave = camera plus corrosion block side.
interface corrode_ctrl_if;
   logic       i_valid;
   logic       i_wb;
   logic       o_pix_valid;
   logic       o_pix_wb;
   logic [7:0] o_err;
   logic       c_valid;
   logic       c_wb;

   modport master (
      input  i_valid, i_wb, c_valid, c_wb,
      output o_pix_valid, o_pix_wb, o_err
   );

   modport slave (
      output i_valid, i_wb, c_valid, c_wb,
      input  o_pix_valid, o_pix_wb, o_err
   );
endinterface

// File: rtl/corrode_ctrl.sv
// Frame sequencer/threshold controller for the corrosion stage; pixel path 1-cycle registered.
// No backpressure: the camera strobe is free-running and pixels are gated, never stalled.
module corrode_ctrl #(
   parameter int IMG_X = 640,
   parameter int IMG_Y = 480,
   parameter int BLK_N = 1200,
   parameter int CNT_W = 16,
   parameter int STEP  = 4
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   corrode_ctrl_if.master   px,
   input  logic             start,
   input  logic             stop,
   input  logic             cfg_wr,
   input  logic [7:0]       cfg_err,
   input  logic             cfg_auto,
   input  logic [CNT_W-1:0] cfg_lo,
   input  logic [CNT_W-1:0] cfg_hi,
   output logic             o_busy,
   output logic             o_frame_done,
   output logic [CNT_W-1:0] o_blk_cnt,
   output logic [CNT_W-1:0] o_white_cnt,
   output logic             o_blk_mismatch
);

   localparam int XW = (IMG_X > 1) ? $clog2(IMG_X) : 1;
   localparam int YW = (IMG_Y > 1) ? $clog2(IMG_Y) : 1;
   localparam logic [XW-1:0]    X_LAST = XW'(IMG_X - 1);
   localparam logic [YW-1:0]    Y_LAST = YW'(IMG_Y - 1);
   localparam logic [CNT_W-1:0] BLK_V  = CNT_W'(BLK_N);
   localparam logic [8:0]       STEP9  = 9'(STEP);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARM   = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   logic [1:0]       state_q;
   logic [1:0]       drain_q;
   logic             stop_pend_q;
   logic [XW-1:0]    x_q;
   logic [YW-1:0]    y_q;
   logic             pix_valid_q;
   logic             pix_wb_q;
   logic [7:0]       err_q;
   logic             pend_q;
   logic [7:0]       p_err_q;
   logic             p_auto_q;
   logic [CNT_W-1:0] p_lo_q;
   logic [CNT_W-1:0] p_hi_q;
   logic             auto_q;
   logic [CNT_W-1:0] lo_q;
   logic [CNT_W-1:0] hi_q;
   logic [CNT_W-1:0] blk_q;
   logic [CNT_W-1:0] wht_q;

   logic             origin;
   logic             last_px;
   logic             publish;
   logic             counting;
   logic             fwd;
   logic [CNT_W-1:0] blk_nxt;
   logic [CNT_W-1:0] wht_nxt;
   logic [8:0]       err_dn9;
   logic [8:0]       err_up9;
   logic [7:0]       err_dn;
   logic [7:0]       err_up;

   assign origin   = px.i_valid && (x_q == '0) && (y_q == '0);
   assign last_px  = px.i_valid && (x_q == X_LAST) && (y_q == Y_LAST);
   assign publish  = (state_q == ST_DRAIN) && (drain_q == 2'd1);
   assign counting = (state_q == ST_RUN) || (state_q == ST_DRAIN);

   assign blk_nxt = (px.c_valid && (blk_q != '1)) ? blk_q + CNT_W'(1) : blk_q;
   assign wht_nxt = (px.c_valid && px.c_wb && (wht_q != '1)) ? wht_q + CNT_W'(1) : wht_q;

   // 9-bit arithmetic: bit 8 flags borrow on the way down and overflow on the way up
   assign err_dn9 = {1'b0, err_q} - STEP9;
   assign err_up9 = {1'b0, err_q} + STEP9;
   assign err_dn  = err_dn9[8] ? 8'd0   : err_dn9[7:0];
   assign err_up  = err_up9[8] ? 8'hFF  : err_up9[7:0];

   always_comb begin
      fwd = 1'b0;
      case (state_q)
         ST_ARM:   fwd = origin && !stop;
         ST_RUN:   fwd = px.i_valid;
         ST_DRAIN: fwd = px.i_valid && !stop_pend_q;
         default:  fwd = 1'b0;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else if (px.i_valid) begin
         if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= (y_q == Y_LAST) ? '0 : y_q + YW'(1);
         end else begin
            x_q <= x_q + XW'(1);
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_IDLE;
         drain_q     <= 2'd0;
         stop_pend_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (start) state_q <= ST_ARM;
            ST_ARM: begin
               if (stop)        state_q <= ST_IDLE;
               else if (origin) state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (stop) stop_pend_q <= 1'b1;
               if (last_px) begin
                  state_q <= ST_DRAIN;
                  drain_q <= 2'd2;
               end
            end
            default: begin
               if (drain_q == 2'd1) begin
                  state_q     <= stop_pend_q ? ST_IDLE : ST_RUN;
                  stop_pend_q <= 1'b0;
                  drain_q     <= 2'd0;
               end else begin
                  drain_q <= drain_q - 2'd1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pix_valid_q <= 1'b0;
         pix_wb_q    <= 1'b0;
      end else begin
         pix_valid_q <= fwd;
         pix_wb_q    <= fwd & px.i_wb;
      end
   end

   // Threshold only moves between frames so a frame is never processed with two values
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         err_q    <= 8'd128;
         pend_q   <= 1'b0;
         p_err_q  <= 8'd0;
         p_auto_q <= 1'b0;
         p_lo_q   <= '0;
         p_hi_q   <= '0;
         auto_q   <= 1'b0;
         lo_q     <= '0;
         hi_q     <= '0;
      end else begin
         if (cfg_wr) begin
            p_err_q  <= cfg_err;
            p_auto_q <= cfg_auto;
            p_lo_q   <= cfg_lo;
            p_hi_q   <= cfg_hi;
            pend_q   <= 1'b1;
         end
         if ((state_q == ST_IDLE) || (state_q == ST_ARM)) begin
            if (cfg_wr) begin
               err_q  <= cfg_err;
               auto_q <= cfg_auto;
               lo_q   <= cfg_lo;
               hi_q   <= cfg_hi;
               pend_q <= 1'b0;
            end else if (pend_q) begin
               err_q  <= p_err_q;
               auto_q <= p_auto_q;
               lo_q   <= p_lo_q;
               hi_q   <= p_hi_q;
               pend_q <= 1'b0;
            end
         end else if (publish) begin
            if (pend_q) begin
               err_q  <= p_err_q;
               auto_q <= p_auto_q;
               lo_q   <= p_lo_q;
               hi_q   <= p_hi_q;
               pend_q <= cfg_wr;
            end else if (auto_q && (wht_nxt > hi_q)) begin
               err_q <= err_dn;
            end else if (auto_q && (wht_nxt < lo_q)) begin
               err_q <= err_up;
            end
         end
      end
   end

   // A decision on the publish cycle itself still lands in the frame being closed
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         blk_q          <= '0;
         wht_q          <= '0;
         o_blk_cnt      <= '0;
         o_white_cnt    <= '0;
         o_blk_mismatch <= 1'b0;
         o_frame_done   <= 1'b0;
      end else if (publish) begin
         o_blk_cnt      <= blk_nxt;
         o_white_cnt    <= wht_nxt;
         o_blk_mismatch <= (blk_nxt != BLK_V);
         o_frame_done   <= 1'b1;
         blk_q          <= '0;
         wht_q          <= '0;
      end else begin
         o_frame_done <= 1'b0;
         if (counting) begin
            blk_q <= blk_nxt;
            wht_q <= wht_nxt;
         end
      end
   end

   assign px.o_pix_valid = pix_valid_q;
   assign px.o_pix_wb    = pix_wb_q;
   assign px.o_err       = err_q;
   assign o_busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_corrode_ctrl.sv
// Directed bench for corrode_ctrl on an 8x4 frame with a free-running pixel stream.
module tb_corrode_ctrl;
   localparam int IMG_X = 8;
   localparam int IMG_Y = 4;
   localparam int BLK_N = 6;
   localparam int CNT_W = 16;
   localparam int STEP  = 4;
   localparam int NPIX  = IMG_X * IMG_Y;

   logic             sys_clk = 1'b0;
   logic             sys_rst_n;
   logic             start, stop, cfg_wr, cfg_auto;
   logic [7:0]       cfg_err;
   logic [CNT_W-1:0] cfg_lo, cfg_hi;
   logic             o_busy, o_frame_done, o_blk_mismatch;
   logic [CNT_W-1:0] o_blk_cnt, o_white_cnt;

   int n_chk   = 0;
   int n_err   = 0;
   int pos     = 0;
   int exp_err = 128;

   corrode_ctrl_if bus ();

   corrode_ctrl #(
      .IMG_X(IMG_X), .IMG_Y(IMG_Y), .BLK_N(BLK_N), .CNT_W(CNT_W), .STEP(STEP)
   ) dut (
      .sys_clk        (sys_clk),
      .sys_rst_n      (sys_rst_n),
      .px             (bus),
      .start          (start),
      .stop           (stop),
      .cfg_wr         (cfg_wr),
      .cfg_err        (cfg_err),
      .cfg_auto       (cfg_auto),
      .cfg_lo         (cfg_lo),
      .cfg_hi         (cfg_hi),
      .o_busy         (o_busy),
      .o_frame_done   (o_frame_done),
      .o_blk_cnt      (o_blk_cnt),
      .o_white_cnt    (o_white_cnt),
      .o_blk_mismatch (o_blk_mismatch)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One pixel per cycle; pixel wb pattern depends only on its frame position
   task automatic tick();
      bus.i_valid = 1'b1;
      bus.i_wb    = pos[0] ^ pos[3];
      @(posedge sys_clk);
      #1;
      pos         = (pos + 1) % NPIX;
      start       = 1'b0;
      stop        = 1'b0;
      cfg_wr      = 1'b0;
      bus.c_valid = 1'b0;
      bus.c_wb    = 1'b0;
   endtask

   // Runs from the current position to the frame's last pixel, then through drain and publish
   task automatic run_frame(input int n_cv, input int n_wb, input bit do_cfg, input int cfg_v,
                            input bit do_stop, input int new_err, input int exp_fwd);
      int fwd   = 0;
      bit first = 1'b1;
      do begin
         for (int k = 0; k < n_cv - 1; k++)
            if (pos == 8 + 2 * k) begin
               bus.c_valid = 1'b1;
               bus.c_wb    = (k < n_wb);
            end
         if (do_cfg && pos == 5) begin
            cfg_wr   = 1'b1;
            cfg_err  = 8'(cfg_v);
            cfg_auto = 1'b1;
            cfg_lo   = 16'd2;
            cfg_hi   = 16'd3;
         end
         if (do_stop && pos == 2) stop = 1'b1;
         tick();
         if (first) check("fd_single", o_frame_done, 0);
         first = 1'b0;
         fwd += int'(bus.o_pix_valid);
      end while (pos != 0);
      check("fwd_cnt", fwd, exp_fwd);
      check("fd_t1", o_frame_done, 0);
      tick();
      check("fd_t2", o_frame_done, 0);
      check("org_fwd", bus.o_pix_valid, !do_stop);
      check("err_hold", bus.o_err, exp_err);
      bus.c_valid = (n_cv > 0);
      bus.c_wb    = (n_cv - 1 < n_wb);
      tick();
      check("fd_t3", o_frame_done, 1);
      check("blk_cnt", o_blk_cnt, n_cv);
      check("white_cnt", o_white_cnt, n_wb);
      check("mismatch", o_blk_mismatch, (n_cv != BLK_N));
      check("err_pub", bus.o_err, new_err);
      check("drain_wb", bus.o_pix_wb, !do_stop);
      check("busy_pub", o_busy, !do_stop);
      exp_err = new_err;
   endtask

   initial begin
      int pre = 0;
      sys_rst_n   = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_wb    = 1'b0;
      bus.c_valid = 1'b0;
      bus.c_wb    = 1'b0;
      start       = 1'b0;
      stop        = 1'b0;
      cfg_wr      = 1'b0;
      cfg_err     = 8'd0;
      cfg_auto    = 1'b0;
      cfg_lo      = '0;
      cfg_hi      = '0;
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_err", bus.o_err, 128);
      check("rst_busy", o_busy, 0);
      check("rst_pv", bus.o_pix_valid, 0);
      check("rst_fd", o_frame_done, 0);
      check("rst_blk", o_blk_cnt, 0);
      check("rst_white", o_white_cnt, 0);
      check("rst_mism", o_blk_mismatch, 0);
      sys_rst_n = 1'b1;

      cfg_wr = 1'b1; cfg_err = 8'd100;
      tick();
      check("cfg_idle", bus.o_err, 100);
      cfg_wr = 1'b1; cfg_err = 8'd128; cfg_auto = 1'b1; cfg_lo = '0; cfg_hi = '0;
      tick();
      check("cfg_idle2", bus.o_err, 128);
      tick();
      start = 1'b1;
      tick();
      check("arm_busy", o_busy, 1);
      pre = int'(bus.o_pix_valid);
      while (pos != 0) begin
         tick();
         pre += int'(bus.o_pix_valid);
      end
      check("arm_gate", pre, 0);

      run_frame(6, 4, 1'b1, 77,  1'b0, 77,  32);
      run_frame(5, 2, 1'b1, 2,   1'b0, 2,   30);
      run_frame(6, 5, 1'b0, 0,   1'b0, 0,   30);
      run_frame(6, 0, 1'b0, 0,   1'b0, 4,   30);
      run_frame(6, 3, 1'b1, 253, 1'b0, 253, 30);
      run_frame(6, 0, 1'b0, 0,   1'b0, 255, 30);
      run_frame(6, 2, 1'b0, 0,   1'b1, 255, 30);
      tick();
      check("idle_gate", bus.o_pix_valid, 0);

      start = 1'b1;
      tick();
      check("arm2_busy", o_busy, 1);
      start = 1'b1; stop = 1'b1;
      tick();
      check("ss_idle", o_busy, 0);
      start = 1'b1;
      tick();
      while (pos != 0) tick();
      repeat (5) tick();
      check("run_busy", o_busy, 1);
      check("run_pv", bus.o_pix_valid, 1);
      check("run_err", bus.o_err, 255);
      #3 sys_rst_n = 1'b0;
      #1;
      check("arst_err", bus.o_err, 128);
      check("arst_busy", o_busy, 0);
      check("arst_pv", bus.o_pix_valid, 0);
      check("arst_blk", o_blk_cnt, 0);
      check("arst_white", o_white_cnt, 0);
      check("arst_fd", o_frame_done, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
